// File: rtl/capture_seq_pkg.sv
// -----------------------------------------------------------------------------
// capture_seq_pkg
// Shared definitions for the capture sequencer:
//   - state_t        : sequencer FSM states
//   - *_BIT / CH_LSB : bit positions inside the sw_ctrl software register
//   - ST_*           : bit positions inside the status register
//   - clamp_len()    : maps the software length register onto 1..2^addr_w
//   - sat16()        : saturates a sample count to the 16-bit status field
// -----------------------------------------------------------------------------
package capture_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // sw_ctrl fields
  localparam int ARM_BIT   = 0;
  localparam int FORCE_BIT = 1;
  localparam int CONT_BIT  = 2;
  localparam int ABORT_BIT = 3;
  localparam int CH_LSB    = 8;

  // status fields
  localparam int ST_BUSY_BIT  = 0;
  localparam int ST_DONE_BIT  = 1;
  localparam int ST_ARMED_BIT = 2;
  localparam int ST_COUNT_LSB = 16;

  // A length of 0, or anything beyond the BRAM depth, means "fill the BRAM".
  function automatic logic [31:0] clamp_len(input logic [31:0] len, input int addr_w);
    logic [31:0] depth;
    depth = 32'd1 << addr_w;
    return ((len == 32'd0) || (len > depth)) ? depth : len;
  endfunction

  function automatic logic [15:0] sat16(input logic [31:0] value);
    return (value > 32'h0000_FFFF) ? 16'hFFFF : value[15:0];
  endfunction

endpackage

// File: rtl/capture_sequencer_if.sv
// -----------------------------------------------------------------------------
// capture_sequencer_if
// Groups the channelised sample stream and the capture BRAM write port.
//   in_valid / in_ch / in_data : sample stream into the sequencer
//   bram_we / bram_addr / bram_din : capture BRAM write port out of it
// Modports:
//   master : the sequencer (consumes samples, drives the BRAM port)
//   slave  : the surrounding fabric (drives samples, observes BRAM writes)
// -----------------------------------------------------------------------------
interface capture_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int CH_W   = 8
) ();

  logic              in_valid;
  logic [CH_W-1:0]   in_ch;
  logic [DATA_W-1:0] in_data;

  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;

  modport master (
    input  in_valid, in_ch, in_data,
    output bram_we, bram_addr, bram_din
  );

  modport slave (
    output in_valid, in_ch, in_data,
    input  bram_we, bram_addr, bram_din
  );

endinterface

// File: rtl/capture_seq_edge.sv
// -----------------------------------------------------------------------------
// capture_seq_edge
// Rising-edge detector for a software register level bit.
//   clk   : clock
//   rst   : synchronous, active-high reset (history cleared to 0)
//   level : register bit, treated as a level
//   rise  : high for the single cycle where level is 1 and was 0 last cycle
// -----------------------------------------------------------------------------
module capture_seq_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic prev;

  // History is updated every cycle regardless of what the FSM does with the
  // edge, so an edge that is ignored is not replayed later.
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/capture_sequencer.sv
// -----------------------------------------------------------------------------
// capture_sequencer
// Arms on a software edge, triggers on a below-threshold phase sample of the
// selected channel (or a software force), then writes a programmed number of
// samples of that channel into a capture BRAM and reports status.
//
// Ports:
//   user_clk, user_rst : clock and synchronous active-high reset
//   sw_ctrl            : bit0 arm, bit1 force_trig, bit2 continuous, bit3 abort,
//                        [15:8] channel select
//   sw_base_kq         : [15:0] signed trigger threshold
//   sw_len             : capture length in samples (0 = full BRAM)
//   bus (master)       : sample stream in, BRAM write port out (registered)
//   status             : bit0 busy, bit1 done, bit2 armed, [31:16] count
//   trig_ts            : trigger timestamp (only with CAPTURE_SEQ_TIMESTAMP_EN)
//
// Build option: define CAPTURE_SEQ_TIMESTAMP_EN to add a free-running 32-bit
// cycle counter and the trig_ts port.
// -----------------------------------------------------------------------------
module capture_sequencer
  import capture_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int CH_W   = 8
) (
  input  logic                user_clk,
  input  logic                user_rst,
  input  logic [31:0]         sw_ctrl,
  input  logic [31:0]         sw_base_kq,
  input  logic [31:0]         sw_len,
  capture_sequencer_if.master bus,
  output logic [31:0]         status
`ifdef CAPTURE_SEQ_TIMESTAMP_EN
  ,
  output logic [31:0]         trig_ts
`endif
);

  // One extra bit so the count can hold the full depth 2^ADDR_W.
  localparam int CNT_W = ADDR_W + 1;

  state_t             state;
  logic [CH_W-1:0]    ch_q;
  logic signed [15:0] thr_q;
  logic               cont_q;
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   count;
  logic               done_q;

  logic        arm_rise;
  logic        force_rise;
  logic        abort;
  logic        ch_match;
  logic        thr_hit;
  logic        last;
  logic        do_write;
  logic        load_cfg;
  logic        trig_accept;
  logic [31:0] len_clamped;

  capture_seq_edge u_arm_edge (
    .clk   (user_clk),
    .rst   (user_rst),
    .level (sw_ctrl[ARM_BIT]),
    .rise  (arm_rise)
  );

  capture_seq_edge u_force_edge (
    .clk   (user_clk),
    .rst   (user_rst),
    .level (sw_ctrl[FORCE_BIT]),
    .rise  (force_rise)
  );

  assign abort       = sw_ctrl[ABORT_BIT];
  assign len_clamped = clamp_len(sw_len, ADDR_W);
  assign ch_match    = bus.in_valid && (bus.in_ch == ch_q);
  assign thr_hit     = ch_match && ($signed(bus.in_data[15:0]) < thr_q);
  assign last        = (count == len_q - CNT_W'(1));

  // A force edge coinciding with a matching sample starts the capture on that
  // sample, the same as a threshold hit: one start, first word captured now.
  assign trig_accept = !abort && (state == ARMED) && (thr_hit || force_rise);
  assign do_write    = !abort && (((state == ARMED) && (thr_hit || (force_rise && ch_match))) ||
                                  ((state == CAPTURE) && ch_match));
  assign load_cfg    = !abort && (((state == IDLE) && arm_rise) || ((state == DONE) && cont_q));

  // NOTE: every register below is assigned with <= so all of them update from
  // the same pre-edge values; mixing in = would make the result depend on
  // statement order inside the block.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state         <= IDLE;
      ch_q          <= '0;
      thr_q         <= '0;
      cont_q        <= 1'b0;
      len_q         <= '0;
      count         <= '0;
      done_q        <= 1'b0;
      bus.bram_we   <= 1'b0;
      bus.bram_addr <= '0;
      bus.bram_din  <= '0;
    end else begin
      bus.bram_we <= 1'b0;

      if (abort) begin
        // count is deliberately left alone so software can see progress.
        state  <= IDLE;
        done_q <= 1'b0;
      end else begin
        if (load_cfg) begin
          ch_q          <= sw_ctrl[CH_LSB +: CH_W];
          thr_q         <= $signed(sw_base_kq[15:0]);
          cont_q        <= sw_ctrl[CONT_BIT];
          len_q         <= len_clamped[CNT_W-1:0];
          count         <= '0;
          bus.bram_addr <= '0;
        end

        if (do_write) begin
          bus.bram_we   <= 1'b1;
          bus.bram_addr <= count[ADDR_W-1:0];
          bus.bram_din  <= bus.in_data;
          count         <= count + CNT_W'(1);
          // In continuous mode done stays up until the first write of the
          // next capture; the final write of a capture raises it again.
          done_q        <= last;
        end

        case (state)
          IDLE: begin
            if (arm_rise) begin
              state  <= ARMED;
              done_q <= 1'b0;
            end
          end
          ARMED: begin
            if (do_write)        state <= last ? DONE : CAPTURE;
            else if (force_rise) state <= CAPTURE;
          end
          CAPTURE: begin
            if (do_write && last) state <= DONE;
          end
          DONE: begin
            state <= cont_q ? ARMED : IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Status is a pure register copy of the sequencer state, so software sees
  // it one cycle behind the FSM.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      status <= '0;
    end else begin
      status                        <= '0;
      status[ST_BUSY_BIT]           <= (state == ARMED) || (state == CAPTURE);
      status[ST_DONE_BIT]           <= done_q;
      status[ST_ARMED_BIT]          <= (state == ARMED);
      status[ST_COUNT_LSB +: 16]    <= sat16(32'(count));
    end
  end

`ifdef CAPTURE_SEQ_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      ts_cnt  <= '0;
      trig_ts <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (trig_accept) trig_ts <= ts_cnt;
    end
  end
`else
  logic unused_trig;
  assign unused_trig = trig_accept;
`endif

  // Register bits with no function in this block.
  logic unused_bits;
  assign unused_bits = ^{sw_ctrl[7:4], sw_ctrl[31:CH_LSB+CH_W], sw_base_kq[31:16],
                         len_clamped[31:CNT_W]};

endmodule

// File: tb/tb_capture_sequencer.sv
// -----------------------------------------------------------------------------
// tb_capture_sequencer
// Directed bench for capture_sequencer with hand-computed expected values.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// With CAPTURE_SEQ_TIMESTAMP_EN defined, the trig_ts port is also exercised.
// -----------------------------------------------------------------------------
module tb_capture_sequencer;
  import capture_seq_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int CH_W   = 8;

  logic        user_clk = 1'b0;
  logic        user_rst;
  logic [31:0] sw_ctrl;
  logic [31:0] sw_base_kq;
  logic [31:0] sw_len;
  logic [31:0] status;
`ifdef CAPTURE_SEQ_TIMESTAMP_EN
  logic [31:0] trig_ts;
`endif

  int vectors    = 0;
  int miscompares = 0;

  capture_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CH_W(CH_W)) bus ();

  capture_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CH_W(CH_W)) dut (
    .user_clk   (user_clk),
    .user_rst   (user_rst),
    .sw_ctrl    (sw_ctrl),
    .sw_base_kq (sw_base_kq),
    .sw_len     (sw_len),
    .bus        (bus),
    .status     (status)
`ifdef CAPTURE_SEQ_TIMESTAMP_EN
    ,
    .trig_ts    (trig_ts)
`endif
  );

  always #5 user_clk = ~user_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge user_clk);
    #1;
  endtask

  task automatic do_reset();
    user_rst = 1'b1;
    step();
    step();
    user_rst = 1'b0;
  endtask

  // Pulse a sw_ctrl bit high for one cycle (edge for arm / force_trig).
  task automatic pulse(input int bit_idx);
    sw_ctrl[bit_idx] = 1'b1;
    step();
    sw_ctrl[bit_idx] = 1'b0;
  endtask

  // Present one sample for one cycle; the registered write is visible on return.
  task automatic send(input logic [7:0] ch, input int data);
    bus.in_valid = 1'b1;
    bus.in_ch    = ch;
    bus.in_data  = 32'(data);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_write(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] din);
    check({tag, ".we"}, 32'(bus.bram_we), 32'(we));
    if (we) begin
      check({tag, ".addr"}, 32'(bus.bram_addr), addr);
      check({tag, ".din"}, bus.bram_din, din);
    end
  endtask

  initial begin
    int bad;
    int k;
    logic [7:0] ch;

    user_rst     = 1'b0;
    sw_ctrl      = '0;
    sw_base_kq   = '0;
    sw_len       = '0;
    bus.in_valid = 1'b0;
    bus.in_ch    = '0;
    bus.in_data  = '0;

    // ---- reset state ----
    do_reset();
    check("rst.we", 32'(bus.bram_we), 32'd0);
    check("rst.addr", 32'(bus.bram_addr), 32'd0);
    check("rst.din", bus.bram_din, 32'd0);
    check("rst.status", status, 32'd0);

    // ---- basic threshold capture: ch5, thr -100, len 4 ----
    sw_base_kq = 32'hFFFF_FF9C;
    sw_len     = 32'd4;
    sw_ctrl    = 32'h0000_0500;
    pulse(ARM_BIT);
    step();
    check("t1.armed_status", status, 32'h0000_0005);
    send(8'd5, -50);
    check_write("t1.s0", 1'b0, 0, 0);
    send(8'd5, -150);
    check_write("t1.s1", 1'b1, 32'd0, 32'hFFFF_FF6A);
    send(8'd5, -20);
    check_write("t1.s2", 1'b1, 32'd1, 32'hFFFF_FFEC);
    send(8'd5, 30);
    check_write("t1.s3", 1'b1, 32'd2, 32'h0000_001E);
    send(8'd5, 40);
    check_write("t1.s4", 1'b1, 32'd3, 32'h0000_0028);
    send(8'd5, 50);
    check_write("t1.s5", 1'b0, 0, 0);
    check("t1.done_status", status, 32'h0004_0002);
    step();
    check("t1.done_held", status, 32'h0004_0002);

    // ---- abort after 3 of 8 writes, abort beats a matching sample ----
    sw_base_kq = 32'd1000;
    sw_len     = 32'd8;
    pulse(ARM_BIT);
    send(8'd5, 1);
    check_write("t2.s0", 1'b1, 32'd0, 32'd1);
    send(8'd5, 2);
    check_write("t2.s1", 1'b1, 32'd1, 32'd2);
    send(8'd5, 3);
    check_write("t2.s2", 1'b1, 32'd2, 32'd3);
    sw_ctrl[ABORT_BIT] = 1'b1;
    send(8'd5, 4);
    check("t2.abort_we", 32'(bus.bram_we), 32'd0);
    step();
    check("t2.abort_status", status, 32'h0003_0000);
    sw_ctrl[ABORT_BIT] = 1'b0;

    // ---- len 0 = full depth via force trigger, no wrap ----
    sw_base_kq = 32'h0000_8000;  // nothing is below -32768
    sw_len     = 32'd0;
    pulse(ARM_BIT);
    pulse(FORCE_BIT);
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      send(8'd5, i);
      if (bus.bram_we !== 1'b1 || 32'(bus.bram_addr) !== 32'(i) || bus.bram_din !== 32'(i))
        bad++;
    end
    check("t3.bad_writes", 32'(bad), 32'd0);
    check("t3.last_addr", 32'(bus.bram_addr), 32'd1023);
    send(8'd5, 2000);
    check("t3.no_wrap_we", 32'(bus.bram_we), 32'd0);
    check("t3.status", status, 32'h0400_0002);

    // ---- continuous mode, len 2 ----
    sw_base_kq = 32'd0;
    sw_len     = 32'd2;
    sw_ctrl    = 32'h0000_0504;
    pulse(ARM_BIT);
    send(8'd5, -1);
    check_write("t4.a0", 1'b1, 32'd0, 32'hFFFF_FFFF);
    send(8'd5, -2);
    check_write("t4.a1", 1'b1, 32'd1, 32'hFFFF_FFFE);
    step();
    check("t4.done_status", status, 32'h0002_0002);
    step();
    check("t4.rearmed_status", status, 32'h0000_0007);
    send(8'd5, 5);
    check_write("t4.no_trig", 1'b0, 0, 0);
    send(8'd5, -3);
    check_write("t4.b0", 1'b1, 32'd0, 32'hFFFF_FFFD);
    send(8'd5, -4);
    check_write("t4.b1", 1'b1, 32'd1, 32'hFFFF_FFFC);
    sw_ctrl = 32'h0000_0508;  // abort, continuous off
    step();
    sw_ctrl = 32'h0000_0500;
    step();
    check("t4.stop_status", status, 32'h0002_0000);

    // ---- interleaved channels 4/5/6, select 5, len 3 ----
    sw_base_kq = 32'h0000_7FFF;
    sw_len     = 32'd3;
    pulse(ARM_BIT);
    k = 0;
    for (int i = 0; i < 9; i++) begin
      ch = 8'(4 + (i % 3));
      send(ch, 100 + i);
      check_write($sformatf("t5.i%0d", i), ch == 8'd5, 32'(k), 32'(100 + i));
      if (ch == 8'd5) k++;
    end
    check("t5.status", status, 32'h0003_0002);

    // ---- reset pulse during capture ----
    sw_len = 32'd8;
    pulse(ARM_BIT);
    send(8'd5, 7);
    check_write("t6.s0", 1'b1, 32'd0, 32'd7);
    send(8'd5, 8);
    check_write("t6.s1", 1'b1, 32'd1, 32'd8);
    user_rst = 1'b1;
    step();
    user_rst = 1'b0;
    check("t6.we", 32'(bus.bram_we), 32'd0);
    check("t6.addr", 32'(bus.bram_addr), 32'd0);
    check("t6.din", bus.bram_din, 32'd0);
    check("t6.status", status, 32'd0);

`ifdef CAPTURE_SEQ_TIMESTAMP_EN
    // ---- trigger timestamp: force edge lands when the counter reads 1000 ----
    check("t7.ts_reset", trig_ts, 32'd0);
    do_reset();
    sw_base_kq = 32'h0000_8000;
    for (int i = 0; i < 999; i++) step();
    pulse(ARM_BIT);
    pulse(FORCE_BIT);
    check("t7.trig_ts", trig_ts, 32'd1000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
